sigmul_cs_resolve: RTL and testbench
====================================

Name: sigmul_cs_resolve

Overview:
- Final carry-propagate stage for significand multiplication. Consumes the redundant sum/carry vector pair left by the last 3:2 compression level and resolves it to a binary product.
- Addition is done sequentially in CHUNK-bit slices, one slice per clock, with a registered inter-slice carry. This trades latency for a short carry chain.
- Sits between the compression tree and normalisation/rounding. Valid/ready handshakes on both sides.

Parameters:
- NSIG, 10, significand fraction width; product width W = 2*NSIG+2.
- CHUNK, 6, bits resolved per cycle (1..W); NCHUNK = ceil(W/CHUNK).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_s/in_c valid.
- in_ready  output  1  block can accept an operand pair.
- in_s  input  W  sum vector, bit 0 aligned to product bit 0.
- in_c  input  W  carry vector, same alignment; absent low bits tied 0 by the producer.
- out_valid  output  1  out_p/out_cout valid.
- out_ready  input  1  consumer accepts result.
- out_p  output  W  (in_s + in_c) mod 2^W.
- out_cout  output  1  carry out of bit W-1; should be 0 for a legal product, reported for checking.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; out_valid=0, out_p=0, out_cout=0, chunk index=0, carry reg=0. in_ready=0 while rst is high.
- States: IDLE, ADD, DONE.
- in_ready = (state==IDLE) && !rst. out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE:
  - Accept when in_valid && in_ready.
  - Latch in_s and in_c into internal registers, clear the carry reg, set index=0, go to ADD.
- ADD, at each edge for slice k = index:
  - lo = k*CHUNK; width wk = CHUNK, except the last slice, where wk = W-(NCHUNK-1)*CHUNK.
  - {cy, p[lo+wk-1:lo]} = s[lo+wk-1:lo] + c[lo+wk-1:lo] + carry. The carry reg takes cy.
  - index increments. After slice NCHUNK-1: out_cout takes that slice's cy, go to DONE.
  - Unwritten out_p bits keep their prior value until overwritten.
  - in_valid is ignored while in ADD.
- DONE:
  - out_p and out_cout are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE. There is no same-cycle re-accept.
- Latency: out_valid rises NCHUNK edges after the accept edge. Throughput is one result per NCHUNK+2 cycles with out_ready held high.
- Input registers are used, so in_s and in_c may change freely after the accept edge.
- CHUNK >= W gives NCHUNK=1 (single-cycle add). CHUNK must not be 0; elaboration fails on CHUNK < 1.
- Reset in ADD or DONE: back to IDLE immediately. The partial result is discarded, out_valid=0, and no output handshake occurs.
- Reset has priority over all handshakes in the same cycle.

Test Plan:
1. Reset, defaults (NSIG=10, W=22, CHUNK=6, NCHUNK=4): assert rst 3 cycles -> out_valid=0, out_p=0, out_cout=0, busy=0; in_ready=1 the first cycle after rst deasserts.
2. Basic add and latency: in_s=0x0003FF, in_c=0x000001 accepted at edge T -> out_valid rises after edge T+4, out_p=0x000400, out_cout=0; in_ready=0 from T to the output handshake.
3. Full carry ripple across all slices: in_s=0x3FFFFF, in_c=0x000001 -> out_p=0x000000, out_cout=1; then in_s=0x2AAAAA, in_c=0x155555 -> out_p=0x3FFFFF, out_cout=0.
4. Backpressure: result pending, out_ready=0 for 10 cycles while in_valid=1 with a new pair -> out_p/out_cout stable, out_valid=1, in_ready=0, new pair not accepted. Raise out_ready -> handshake, IDLE for one cycle, then the new pair is accepted.
5. Reset mid-operation: accept in_s=0x123456 & 0x3FFFFF, assert rst after 2 ADD edges -> next cycle state IDLE, out_valid=0, busy=0, no result emitted. A subsequent pair resolves correctly (check against a model).
6. Parameter corners:
   - CHUNK=22: in_s=0x12345, in_c=0x0ABCD -> out_p=0x1CF12 one edge after accept.
   - CHUNK=1: 22-edge latency, plus 1000 random (s,c) pairs with random out_ready checked against (s+c) mod 2^22 and the bit-22 carry.

Source files
------------

// File: rtl/sigmul_cs_resolve.sv
// Final carry-propagate stage for the significand multiplier: resolves the
// redundant sum/carry pair into a binary product, one CHUNK-bit slice per clock.
module sigmul_cs_resolve #(
    parameter  int NSIG  = 10,
    parameter  int CHUNK = 6,
    localparam int W     = 2*NSIG+2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic         out_cout,
    output logic         busy
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = (W + CHUNK_SAFE - 1) / CHUNK_SAFE;
    // A chunk wider than the product collapses to a single W-bit lane.
    localparam int LANE_W     = (CHUNK_SAFE < W) ? CHUNK_SAFE : W;
    localparam int LAST_W     = W - (NCHUNK-1)*LANE_W;
    localparam int IDX_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1) begin : g_chunk_check
            $error("sigmul_cs_resolve: CHUNK must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t             state_reg;
    logic [W-1:0]       s_reg;
    logic [W-1:0]       c_reg;
    logic [W-1:0]       p_reg;
    logic [W-1:0]       p_next;
    logic               carry_reg;
    logic               cout_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic [LANE_W-1:0]  s_lane [NCHUNK];
    logic [LANE_W-1:0]  c_lane [NCHUNK];
    logic [LANE_W-1:0]  s_cur;
    logic [LANE_W-1:0]  c_cur;
    logic [LANE_W:0]    sum_cur;
    logic               last_slice;
    logic               slice_cy;

    // Each lane is the operand slice zero-extended to the adder width; the
    // narrower top lane has its carry picked off at bit LAST_W instead.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_lane
            localparam int LO = gi*LANE_W;
            localparam int WK = (gi == NCHUNK-1) ? LAST_W : LANE_W;

            assign s_lane[gi] = LANE_W'(s_reg[LO +: WK]);
            assign c_lane[gi] = LANE_W'(c_reg[LO +: WK]);
            assign p_next[LO +: WK] = (idx_reg == IDX_W'(gi)) ? sum_cur[WK-1:0]
                                                              : p_reg[LO +: WK];
        end
    endgenerate

    always_comb begin
        s_cur      = s_lane[idx_reg];
        c_cur      = c_lane[idx_reg];
        sum_cur    = {1'b0, s_cur} + {1'b0, c_cur} + {{LANE_W{1'b0}}, carry_reg};
        last_slice = (idx_reg == IDX_W'(NCHUNK-1));
        slice_cy   = last_slice ? sum_cur[LAST_W] : sum_cur[LANE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            p_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_reg     <= in_s;
                        c_reg     <= in_c;
                        carry_reg <= 1'b0;
                        idx_reg   <= '0;
                        state_reg <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    p_reg     <= p_next;
                    carry_reg <= slice_cy;
                    if (last_slice) begin
                        cout_reg  <= slice_cy;
                        idx_reg   <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_p     = p_reg;
    assign out_cout  = cout_reg;

endmodule

// File: tb/tb_sigmul_cs_resolve.sv
// Directed checks of the sliced carry-propagate adder at CHUNK=6, 22 and 1,
// plus a randomised CHUNK=1 run against an (s+c) model.
module tb_sigmul_cs_resolve;

    localparam int W = 22;
    localparam logic [W-1:0] MASK = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main instance, CHUNK=6
    logic         m_in_valid = 0, m_in_ready, m_out_valid, m_out_ready = 0, m_out_cout, m_busy;
    logic [W-1:0] m_in_s = '0, m_in_c = '0, m_out_p;
    // CHUNK=22 instance
    logic         h_in_valid = 0, h_in_ready, h_out_valid, h_out_ready = 0, h_out_cout, h_busy;
    logic [W-1:0] h_in_s = '0, h_in_c = '0, h_out_p;
    // CHUNK=1 instance
    logic         u_in_valid = 0, u_in_ready, u_out_valid, u_out_ready = 0, u_out_cout, u_busy;
    logic [W-1:0] u_in_s = '0, u_in_c = '0, u_out_p;

    sigmul_cs_resolve #(.NSIG(10), .CHUNK(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_s(m_in_s), .in_c(m_in_c),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_p(m_out_p),
        .out_cout(m_out_cout), .busy(m_busy)
    );

    sigmul_cs_resolve #(.NSIG(10), .CHUNK(22)) dut_c22 (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_s(h_in_s), .in_c(h_in_c),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_p(h_out_p),
        .out_cout(h_out_cout), .busy(h_busy)
    );

    sigmul_cs_resolve #(.NSIG(10), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .in_s(u_in_s), .in_c(u_in_c),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_p(u_out_p),
        .out_cout(u_out_cout), .busy(u_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // From just after the accept edge: count edges until out_valid is seen,
    // noting whether in_ready ever rose in the meantime.
    task automatic m_wait_result(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (m_in_ready) rdy_seen = 1;
        end while (!m_out_valid && n < 100);
    endtask

    task automatic m_run(input string tag, input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W:0] model;
        int n;
        bit rdy_seen;
        model = {1'b0, s} + {1'b0, c};
        @(negedge clk);
        m_in_valid = 1;
        m_in_s = s;
        m_in_c = c;
        chk({tag, "_in_ready"}, 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        m_in_valid = 0;
        m_in_s = ~s;
        m_in_c = s ^ c;
        m_wait_result(n, rdy_seen);
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_ready_low"}, 32'(rdy_seen), 32'd0);
        chk({tag, "_p"}, 32'(m_out_p), 32'(model[W-1:0]));
        chk({tag, "_cout"}, 32'(m_out_cout), 32'(model[W]));
        $display("%s: s=%06h c=%06h -> p=%06h cout=%0b lat=%0d", tag, s, c, m_out_p, m_out_cout, n);
        m_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m_out_ready = 0;
        chk({tag, "_valid_drop"}, 32'(m_out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(m_in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit rdy_seen;
        bit seen;
        logic [W-1:0] ap, s, c;
        logic [W:0] model;

        // 1. reset defaults
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(m_out_valid), 32'd0);
        chk("rst_out_p", 32'(m_out_p), 32'd0);
        chk("rst_out_cout", 32'(m_out_cout), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_in_ready_held", 32'(m_in_ready), 32'd0);
        rst = 0;
        #1;
        chk("rst_in_ready_release", 32'(m_in_ready), 32'd1);
        $display("reset: out_valid=%0b out_p=%06h busy=%0b in_ready=%0b", m_out_valid, m_out_p, m_busy, m_in_ready);

        // 2. basic add and latency; 3. full ripple and alternating patterns
        m_run("basic", 22'h0003FF, 22'h000001);
        chk("basic_abs_p", 32'(m_out_p), 32'h000400);
        m_run("ripple", 22'h3FFFFF, 22'h000001);
        chk("ripple_abs_p", 32'(m_out_p), 32'h000000);
        chk("ripple_abs_cout", 32'(m_out_cout), 32'd1);
        m_run("alt", 22'h2AAAAA, 22'h155555);
        chk("alt_abs_p", 32'(m_out_p), 32'h3FFFFF);
        chk("alt_abs_cout", 32'(m_out_cout), 32'd0);

        // 4. backpressure with a competing input pair
        @(negedge clk);
        m_in_valid = 1;
        m_in_s = 22'h000FFF;
        m_in_c = 22'h000001;
        @(posedge clk);
        #1;
        m_in_valid = 0;
        m_wait_result(n, rdy_seen);
        chk("bp_first_p", 32'(m_out_p), 32'h001000);
        m_in_valid = 1;
        m_in_s = 22'h100000;
        m_in_c = 22'h0ABCDE;
        ap = m_out_p;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_p", 32'(m_out_p), 32'(ap));
            chk("bp_hold_cout", 32'(m_out_cout), 32'd0);
            chk("bp_hold_valid", 32'(m_out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(m_in_ready), 32'd0);
        end
        $display("backpressure: held p=%06h for 10 cycles", m_out_p);
        m_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m_out_ready = 0;
        chk("bp_idle_valid", 32'(m_out_valid), 32'd0);
        chk("bp_idle_busy", 32'(m_busy), 32'd0);
        chk("bp_idle_in_ready", 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        m_in_valid = 0;
        m_in_s = '0;
        @(negedge clk);
        chk("bp_second_busy", 32'(m_busy), 32'd1);
        m_wait_result(n, rdy_seen);
        chk("bp_second_latency", 32'(n), 32'd4);
        chk("bp_second_p", 32'(m_out_p), 32'h1ABCDE);
        $display("backpressure: second pair p=%06h lat=%0d", m_out_p, n);
        m_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        m_out_ready = 0;

        // 5. reset during ADD
        m_in_valid = 1;
        m_in_s = 22'h123456 & MASK;
        m_in_c = 22'h00ABCD;
        @(posedge clk);
        #1;
        m_in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(m_out_valid), 32'd0);
        chk("midrst_busy", 32'(m_busy), 32'd0);
        chk("midrst_p", 32'(m_out_p), 32'd0);
        chk("midrst_in_ready", 32'(m_in_ready), 32'd0);
        rst = 0;
        #1;
        chk("midrst_release_ready", 32'(m_in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_out_valid || m_busy) seen = 1;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        $display("midreset: aborted pair discarded");
        m_run("after_rst", 22'h35A5A5, 22'h0C3C3C);

        // 6a. CHUNK=22: single-edge add
        @(negedge clk);
        h_in_valid = 1;
        h_in_s = 22'h012345;
        h_in_c = 22'h00ABCD;
        chk("c22_in_ready", 32'(h_in_ready), 32'd1);
        @(posedge clk);
        #1;
        h_in_valid = 0;
        h_in_s = '1;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!h_out_valid && n < 50);
        chk("c22_latency", 32'(n), 32'd1);
        chk("c22_p", 32'(h_out_p), 32'h01CF12);
        chk("c22_cout", 32'(h_out_cout), 32'd0);
        $display("c22: p=%06h cout=%0b lat=%0d", h_out_p, h_out_cout, n);
        h_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        h_out_ready = 0;
        chk("c22_valid_drop", 32'(h_out_valid), 32'd0);

        // 6b. CHUNK=1: directed 22-edge latency, then random pairs
        u_in_valid = 1;
        u_in_s = 22'h3FFFFF;
        u_in_c = 22'h000001;
        @(posedge clk);
        #1;
        u_in_valid = 0;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!u_out_valid && n < 100);
        chk("c1_latency", 32'(n), 32'd22);
        chk("c1_p", 32'(u_out_p), 32'h000000);
        chk("c1_cout", 32'(u_out_cout), 32'd1);
        $display("c1: p=%06h cout=%0b lat=%0d", u_out_p, u_out_cout, n);
        u_out_ready = 1;
        @(posedge clk);

        for (int t = 0; t < 1000; t++) begin
            bit done;
            @(negedge clk);
            u_out_ready = 0;
            s = W'($urandom) & MASK;
            c = W'($urandom) & MASK;
            model = {1'b0, s} + {1'b0, c};
            u_in_valid = 1;
            u_in_s = s;
            u_in_c = c;
            chk("c1r_in_ready", 32'(u_in_ready), 32'd1);
            @(posedge clk);
            #1;
            u_in_valid = 0;
            u_in_s = W'($urandom);
            u_in_c = W'($urandom);
            done = 0;
            n = 0;
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
                u_out_ready = 1'($urandom_range(0, 1));
                if (u_out_valid && u_out_ready) begin
                    chk("c1r_p", 32'(u_out_p), 32'(model[W-1:0]));
                    chk("c1r_cout", 32'(u_out_cout), 32'(model[W]));
                    done = 1;
                end
            end
            chk("c1r_completed", 32'(done), 32'd1);
            $display("c1 rand %0d: s=%06h c=%06h -> p=%06h cout=%0b", t, s, c, u_out_p, u_out_cout);
            @(posedge clk);
        end
        @(negedge clk);
        u_out_ready = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
